// File: rtl/ez8_pkg.sv
// ez8_pkg: shared definitions for the skip sequencer.
//   - opcodes of the conditional-skip instructions (SKZ, SBS, SBC)
//   - condition codes that SKZ decodes from selector[2:0]
//   - sequencer FSM state encoding
package ez8_pkg;

    localparam logic [3:0] OP_SKZ = 4'b1010;  // skip on condition code
    localparam logic [3:0] OP_SBS = 4'b1011;  // skip if bit set
    localparam logic [3:0] OP_SBC = 4'b1100;  // skip if bit clear

    typedef enum logic [2:0] {
        CC_ZERO   = 3'b000,  // V == 0
        CC_NZERO  = 3'b001,  // V != 0
        CC_MSB1   = 3'b010,  // V[MSB] = 1
        CC_MSB0   = 3'b011,  // V[MSB] = 0
        CC_GT     = 3'b100,  // V > 0, signed
        CC_LE     = 3'b101,  // V <= 0, signed
        CC_EQ     = 3'b110,  // reg == accum
        CC_LT     = 3'b111   // reg < accum, signed
    } cond_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SKIP = 1'b1
    } seq_state_e;

endpackage

// File: rtl/skip_cond.sv
// skip_cond: combinational skip-condition evaluation.
// Ports:
//   opcode      - instruction opcode; only SKZ/SBS/SBC can produce a true condition
//   reg_value   - register-file operand
//   accum_value - accumulator operand
//   selector    - condition code (SKZ, low 3 bits) or bit index (SBS/SBC)
//   direction   - operand select, 1 = reg_value, 0 = accum_value
//   cond_o      - condition result
module skip_cond
    import ez8_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] reg_value,
    input  logic [DATA_WIDTH-1:0] accum_value,
    input  logic [SEL_WIDTH-1:0]  selector,
    input  logic                  direction,
    output logic                  cond_o
);

    logic [DATA_WIDTH-1:0] v;
    logic [DATA_WIDTH-1:0] v_shifted;
    logic                  sel_in_range;
    logic                  v_gt_zero;

    always_comb begin
        v            = direction ? reg_value : accum_value;
        // A shift keeps the bit pick legal for any selector width; an
        // out-of-range index is then rejected explicitly for both polarities.
        v_shifted    = v >> selector;
        sel_in_range = (32'(selector) < 32'(DATA_WIDTH));
        v_gt_zero    = ($signed(v) > $signed({DATA_WIDTH{1'b0}}));
        cond_o       = 1'b0;

        case (opcode)
            OP_SKZ: begin
                case (cond_code_e'(selector[2:0]))
                    CC_ZERO:  cond_o = (v == '0);
                    CC_NZERO: cond_o = (v != '0);
                    CC_MSB1:  cond_o = v[DATA_WIDTH-1];
                    CC_MSB0:  cond_o = ~v[DATA_WIDTH-1];
                    CC_GT:    cond_o = v_gt_zero;
                    CC_LE:    cond_o = ~v_gt_zero;
                    CC_EQ:    cond_o = (reg_value == accum_value);
                    CC_LT:    cond_o = ($signed(reg_value) < $signed(accum_value));
                    default:  cond_o = 1'b0;
                endcase
            end
            OP_SBS:  cond_o = sel_in_range & v_shifted[0];
            OP_SBC:  cond_o = sel_in_range & ~v_shifted[0];
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/skip_sequencer.sv
// skip_sequencer: decides conditional skips in the execute stage and squashes
// the following 1..MAX_SKIP consumed instructions.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | evaluating conditions; squash = 0
//   ST_SKIP | squashing; cnt = consumed instructions left to annul
//
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   valid_in     - instruction present in execute
//   stall        - instruction not consumed this cycle
//   flush_in     - taken jump/branch, abandons any skip
//   opcode, reg_value, accum_value, selector, direction - condition inputs
//   skip_count   - instructions to squash (0 -> 1, saturates at MAX_SKIP)
//   squash       - annul the instruction in execute (registered)
//   skip_taken   - one-cycle pulse after an accepted skip decision
//   skip_events  - saturating count of accepted skip decisions
module skip_sequencer
    import ez8_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(DATA_WIDTH),
    parameter int MAX_SKIP   = 3,
    parameter int CNT_WIDTH  = $clog2(MAX_SKIP + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush_in,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] reg_value,
    input  logic [DATA_WIDTH-1:0] accum_value,
    input  logic [SEL_WIDTH-1:0]  selector,
    input  logic                  direction,
    input  logic [CNT_WIDTH-1:0]  skip_count,
    output logic                  squash,
    output logic                  skip_taken,
    output logic [15:0]           skip_events
);

    logic                 cond;
    logic                 consume;
    logic [CNT_WIDTH-1:0] load_cnt;

    seq_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 squash_q;
    logic                 skip_taken_q;
    logic [15:0]          skip_events_q;

    skip_cond #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_cond (
        .opcode      (opcode),
        .reg_value   (reg_value),
        .accum_value (accum_value),
        .selector    (selector),
        .direction   (direction),
        .cond_o      (cond)
    );

    assign consume = valid_in & ~stall;

    always_comb begin
        if (skip_count == '0) begin
            load_cnt = CNT_WIDTH'(1);
        end else if (32'(skip_count) > 32'(MAX_SKIP)) begin
            load_cnt = CNT_WIDTH'(MAX_SKIP);
        end else begin
            load_cnt = skip_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            squash_q      <= 1'b0;
            skip_taken_q  <= 1'b0;
            skip_events_q <= '0;
        end else begin
            skip_taken_q <= 1'b0;
            if (flush_in) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                squash_q <= 1'b0;
            end else if (consume) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cond) begin
                            state_q      <= ST_SKIP;
                            cnt_q        <= load_cnt;
                            squash_q     <= 1'b1;
                            skip_taken_q <= 1'b1;
                            if (skip_events_q != 16'hFFFF) begin
                                skip_events_q <= skip_events_q + 16'd1;
                            end
                        end
                    end
                    ST_SKIP: begin
                        // Conditions are ignored here: squashed instructions
                        // never start a new skip.
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            state_q  <= ST_IDLE;
                            squash_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        squash_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign squash      = squash_q;
    assign skip_taken  = skip_taken_q;
    assign skip_events = skip_events_q;

endmodule
